// File: rtl/seq_div.sv
// ============================================================================
//  Module   : seq_div
//  Purpose  : Restoring radix-2 sequential divider, signed or unsigned,
//             one quotient bit per clock, with divide-by-zero and overflow flags.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module seq_div #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         sign,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Quot,
    output logic [N-1:0] Rem,
    output logic         DivZero,
    output logic         Ofl,
    output logic         Zero,
    output logic         Neg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [3:0] c_LAST_STEP = 4'(N - 1);
    localparam logic [N:0] c_MIN_MAG   = {2'b01, {(N-1){1'b0}}};

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [N:0]   r_rem;
    logic [N-1:0] r_dvd;
    logic [N:0]   r_dvs;
    logic         r_sgn;
    logic         r_neg_a;
    logic         r_neg_b;
    logic         r_ofl;

    // Magnitudes are formed in N+1 bits so that |-2^(N-1)| stays representable.
    logic         w_a_neg;
    logic         w_b_neg;
    logic [N:0]   w_a_ext;
    logic [N:0]   w_b_ext;
    logic [N:0]   w_mag_a;
    logic [N:0]   w_mag_b;

    assign w_a_neg = sign & A[N-1];
    assign w_b_neg = sign & B[N-1];
    assign w_a_ext = {w_a_neg, A};
    assign w_b_ext = {w_b_neg, B};
    assign w_mag_a = w_a_neg ? ((N+1)'(0) - w_a_ext) : w_a_ext;
    assign w_mag_b = w_b_neg ? ((N+1)'(0) - w_b_ext) : w_b_ext;

    logic [N:0]   w_shift;
    logic [N+1:0] w_trial;
    logic         w_fits;

    assign w_shift = {r_rem[N-1:0], r_dvd[N-1]};
    assign w_trial = {1'b0, w_shift} - {1'b0, r_dvs};
    assign w_fits  = ~w_trial[N+1];

    logic [N-1:0] w_q_fix;
    logic [N-1:0] w_r_fix;

    assign w_q_fix = (r_sgn & (r_neg_a ^ r_neg_b)) ? (N'(0) - r_dvd) : r_dvd;
    assign w_r_fix = (r_sgn & r_neg_a) ? (N'(0) - r_rem[N-1:0]) : r_rem[N-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_dvd   <= '0;
            r_dvs   <= '0;
            r_sgn   <= 1'b0;
            r_neg_a <= 1'b0;
            r_neg_b <= 1'b0;
            r_ofl   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            Quot    <= '0;
            Rem     <= '0;
            DivZero <= 1'b0;
            Ofl     <= 1'b0;
            Zero    <= 1'b1;
            Neg     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (B == '0) begin
                            Quot    <= '1;
                            Rem     <= A;
                            DivZero <= 1'b1;
                            Ofl     <= 1'b0;
                            Zero    <= 1'b0;
                            Neg     <= 1'b1;
                            done    <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_dvd   <= w_mag_a[N-1:0];
                            r_dvs   <= w_mag_b;
                            r_sgn   <= sign;
                            r_neg_a <= w_a_neg;
                            r_neg_b <= w_b_neg;
                            r_ofl   <= sign && (w_mag_a == c_MIN_MAG) && (B == '1);
                            r_cnt   <= '0;
                            r_rem   <= '0;
                            busy    <= 1'b1;
                            r_state <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    // Quotient bits shift into the dividend register as it empties.
                    r_rem   <= w_fits ? w_trial[N:0] : w_shift;
                    r_dvd   <= {r_dvd[N-2:0], w_fits};
                    r_cnt   <= r_cnt + 4'd1;
                    if (r_cnt == c_LAST_STEP) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    Quot    <= w_q_fix;
                    Rem     <= w_r_fix;
                    DivZero <= 1'b0;
                    Ofl     <= r_ofl;
                    Zero    <= (w_q_fix == '0);
                    Neg     <= w_q_fix[N-1];
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_seq_div.sv
// ============================================================================
//  Module   : tb_seq_div
//  Purpose  : Directed self-checking bench for seq_div with hand-computed results.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seq_div;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        sign;
    logic [15:0] A;
    logic [15:0] B;
    logic        busy;
    logic        done;
    logic [15:0] Quot;
    logic [15:0] Rem;
    logic        DivZero;
    logic        Ofl;
    logic        Zero;
    logic        Neg;

    int checks   = 0;
    int failures = 0;
    int lat;
    int nbusy;
    int extra;

    seq_div #(.N(16)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .sign    (sign),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Quot    (Quot),
        .Rem     (Rem),
        .DivZero (DivZero),
        .Ofl     (Ofl),
        .Zero    (Zero),
        .Neg     (Neg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Presents operands with start for one edge (edge 0).
    task automatic kick(input logic s, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        sign  = s;
        A     = a;
        B     = b;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // k = index of the edge just before the sample; inj>=0 pulses a stray start.
    task automatic wait_done(input int inj);
        lat   = -1;
        nbusy = 0;
        extra = 0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == inj) begin
                start = 1'b1;
                A     = 16'd9;
                B     = 16'd3;
            end else if (k == inj + 1) begin
                start = 1'b0;
            end
            if (busy) nbusy++;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        if (lat < 0) chk("timeout", 32'd0, 32'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("single_done", extra, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b1;
        sign  = 1'b0;
        A     = 16'd5;
        B     = 16'd1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_quot", Quot, 0);
        chk("rst_rem",  Rem, 0);
        chk("rst_zero", Zero, 1);
        chk("rst_neg",  Neg, 0);
        chk("rst_dz",   DivZero, 0);
        chk("rst_ofl",  Ofl, 0);
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_start_ignored", busy, 0);

        kick(1'b0, 16'd100, 16'd7);
        wait_done(-5);
        chk("u100_7_lat",  lat, 17);
        chk("u100_7_busy", nbusy, 17);
        chk("u100_7_q",    Quot, 16'd14);
        chk("u100_7_r",    Rem, 16'd2);
        chk("u100_7_zero", Zero, 0);
        chk("u100_7_ofl",  Ofl, 0);
        chk("u100_7_dz",   DivZero, 0);
        chk("hold_q",      Quot, 16'd14);

        kick(1'b1, 16'hFFF9, 16'd2);
        wait_done(-5);
        chk("sm7_2_q",   Quot, 16'hFFFD);
        chk("sm7_2_r",   Rem, 16'hFFFF);
        chk("sm7_2_neg", Neg, 1);

        kick(1'b1, 16'd7, 16'hFFFE);
        wait_done(-5);
        chk("s7_m2_q", Quot, 16'hFFFD);
        chk("s7_m2_r", Rem, 16'd1);

        kick(1'b1, 16'hFFF9, 16'hFFFE);
        wait_done(-5);
        chk("sm7_m2_q",   Quot, 16'd3);
        chk("sm7_m2_r",   Rem, 16'hFFFF);
        chk("sm7_m2_neg", Neg, 0);

        kick(1'b0, 16'h1234, 16'd0);
        wait_done(-5);
        chk("dz_lat",  lat, 0);
        chk("dz_busy", nbusy, 0);
        chk("dz_q",    Quot, 16'hFFFF);
        chk("dz_r",    Rem, 16'h1234);
        chk("dz_flag", DivZero, 1);
        chk("dz_ofl",  Ofl, 0);

        kick(1'b1, 16'h8000, 16'hFFFF);
        wait_done(-5);
        chk("ofl_lat", lat, 17);
        chk("ofl_q",   Quot, 16'h8000);
        chk("ofl_r",   Rem, 16'h0000);
        chk("ofl_flag", Ofl, 1);
        chk("ofl_dz",  DivZero, 0);

        kick(1'b0, 16'h8000, 16'hFFFF);
        wait_done(-5);
        chk("u8000_q",    Quot, 16'h0000);
        chk("u8000_r",    Rem, 16'h8000);
        chk("u8000_zero", Zero, 1);
        chk("u8000_ofl",  Ofl, 0);

        kick(1'b0, 16'd50, 16'd5);
        wait_done(5);
        chk("ign_lat", lat, 17);
        chk("ign_q",   Quot, 16'd10);
        chk("ign_r",   Rem, 16'd0);

        kick(1'b0, 16'hFFFF, 16'd1);
        wait_done(-5);
        chk("uffff_q", Quot, 16'hFFFF);
        chk("uffff_r", Rem, 16'd0);

        kick(1'b0, 16'hFFFF, 16'd1);
        for (int k = 0; k <= 8; k++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_q",    Quot, 0);
        chk("abort_r",    Rem, 0);
        chk("abort_zero", Zero, 1);
        rst_n = 1'b1;
        extra = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk("abort_no_done", extra, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 Parameter N, default 16, operand and result width; only N=16 is verified.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; one clock; reset is synchronous and active-low.
REQ-004 start  input  1  request a divide; accepted only in IDLE.
REQ-005 sign  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 A  input  16  dividend; sampled on the accepting edge.
REQ-007 B  input  16  divisor; sampled on the accepting edge.
REQ-008 busy  output  1  high while in CALC or FIX.
REQ-009 done  output  1  one-cycle pulse; results are valid.
REQ-010 Quot  output  16  quotient, registered.
REQ-011 Rem  output  16  remainder, registered.
REQ-012 DivZero  output  1  divisor was zero.
REQ-013 Ofl  output  1  signed overflow (-32768 / -1).
REQ-014 Zero  output  1  Quot == 0.
REQ-015 Neg  output  1  Quot[15].

Function
REQ-016 States SHALL be IDLE, CALC, FIX and DONE; the reset state SHALL be IDLE.
REQ-017 Accepting edge: the edge where start=1 in IDLE; start in any other state SHALL be ignored, with no effect on the operation in flight.
REQ-018 On the accepting edge with B != 0, the block SHALL latch magnitudes |A| and |B| (raw values when sign=0), the operand signs, and clear a 4-bit iteration counter and 17-bit partial remainder; next state SHALL be CALC.
REQ-019 CALC SHALL perform one restoring radix-2 step per cycle, MSB-first:
- shift remainder left, bringing in the next dividend bit;
- trial-subtract divisor;
- keep the result if non-negative and set that quotient bit to 1, else restore and set it to 0.
REQ-020 CALC SHALL last exactly 16 cycles; on the edge where the counter is 15, next state SHALL be FIX.
REQ-021 FIX SHALL apply signs:
- quotient negated when sign=1 and operand signs differ (truncation toward zero);
- remainder negated when sign=1 and A was negative (remainder takes the dividend's sign).
REQ-022 FIX SHALL load Quot and Rem and update DivZero, Ofl, Zero and Neg; next state SHALL be DONE.
REQ-023 done SHALL be 1 only in DONE, for exactly one cycle; next state SHALL be IDLE unconditionally.
REQ-024 Latency: done SHALL be high in the cycle following the 17th rising edge after the accepting edge (edge 0).
REQ-025 B == 0 on the accepting edge: next state SHALL be DONE directly, with Quot=16'hFFFF, Rem=A, DivZero=1 and Ofl=0; done SHALL be high in the cycle after edge 0.
REQ-026 sign=1, A=16'h8000, B=16'hFFFF: the normal 17-edge path SHALL be used, with Quot=16'h8000, Rem=0 and Ofl=1.
REQ-027 Ofl SHALL be 0 for all other cases, including every unsigned division.
REQ-028 Magnitude of -32768 SHALL be computed in 17 bits so that |16'h8000| = 32768 divides correctly.
REQ-029 Quot, Rem and all flags SHALL hold their last values from DONE until the next operation reaches FIX or the divide-by-zero DONE.
REQ-030 Zero and Neg SHALL track the registered Quot, updated only with Quot.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force state IDLE, and clear busy, done, Quot, Rem, DivZero, Ofl, Neg, the counter and the remainder.
REQ-032 While rst_n=0, Zero SHALL be 1.
REQ-033 Reset mid-operation (CALC or FIX) SHALL abort with no done pulse.
REQ-034 start asserted in the same cycle as rst_n=0 SHALL be ignored.

Verification
REQ-035 sign=0, A=100, B=7 -> busy high for 17 cycles, done in cycle after edge 17, Quot=14, Rem=2, Zero=0, Ofl=0.
REQ-036 sign=1, A=16'hFFF9 (-7), B=2 -> Quot=16'hFFFD (-3), Rem=16'hFFFF (-1), Neg=1.
REQ-037 sign=0, A=16'h1234, B=0 -> done in cycle after edge 0, Quot=16'hFFFF, Rem=16'h1234, DivZero=1, busy never 1.
REQ-038 sign=1, A=16'h8000, B=16'hFFFF -> Quot=16'h8000, Rem=0, Ofl=1; repeating with sign=0 -> Quot=0, Rem=16'h8000, Zero=1, Ofl=0.
REQ-039 Start 50/5; pulse start with A=9, B=3 at CALC cycle 5 -> ignored, results Quot=10, Rem=0, exactly one done pulse.
REQ-040 Start 16'hFFFF/1; drive rst_n=0 at CALC cycle 8 -> next cycle busy=0, done=0, Quot=0, Rem=0, Zero=1, and no later done pulse.
